// File: rtl/serial_cmd_pkg.sv
// Shared types and constants for the serial command receiver: parser states,
// protocol ASCII codes and the hex-digit decoder.
package serial_cmd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEX_HI,
        S_HEX_LO,
        S_TERM,
        S_DISCARD
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] nibble;
    } hex_t;

    localparam logic [7:0] ASCII_L  = 8'h4C;
    localparam logic [7:0] ASCII_C  = 8'h43;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_K  = 8'h4B;
    localparam logic [7:0] ASCII_Q  = 8'h3F;

    // 'a'-'f' and 'A'-'F' share the same low nibble (1..6), so +9 maps both to 10..15.
    function automatic hex_t hex_decode(input logic [7:0] b);
        hex_t h;
        h.valid  = 1'b1;
        h.nibble = b[3:0];
        if (b >= 8'h30 && b <= 8'h39) begin
            h.nibble = b[3:0];
        end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
            h.nibble = b[3:0] + 4'd9;
        end else begin
            h.valid = 1'b0;
        end
        return h;
    endfunction

endpackage

// File: rtl/serial_ack_sender.sv
// Single-slot acknowledge sender: newest request wins, issued as a one-cycle
// transmit strobe once the transmitter is idle.
module serial_ack_sender (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] req_byte,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       new_tx_data
);

    logic       pending_q;
    logic [7:0] pend_byte_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= 1'b0;
            tx_data     <= 8'h00;
            new_tx_data <= 1'b0;
        end else begin
            new_tx_data <= 1'b0;
            if (pending_q && !tx_busy) begin
                tx_data     <= pend_byte_q;
                new_tx_data <= 1'b1;
                pending_q   <= 1'b0;
            end
            // A request landing on the issue cycle re-arms the slot.
            if (req) pending_q <= 1'b1;
        end
    end

    // NOTE: the payload register needs no reset; it is only read while
    // pending_q is set, and pending_q is reset.
    always_ff @(posedge clk) begin
        if (req) pend_byte_q <= req_byte;
    end

endmodule

// File: rtl/serial_cmd_receiver.sv
// ASCII command parser ("Lhh<T>" / "C<T>") driving the LED register, with
// stall timeout. Define SERIAL_CMD_ACK_EN to return 'K'/'?' acknowledge bytes.
module serial_cmd_receiver
    import serial_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       new_rx_data,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    output logic [7:0] led,
    output logic       cmd_done,
    output logic       cmd_error
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [7:0]       staged_q, staged_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       led_d;
    logic             done_d, error_d;
    logic             is_term;
    hex_t             hx;

    assign hx      = hex_decode(rx_data);
    assign is_term = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);

    // NOTE: every signal gets its default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        staged_d = staged_q;
        cnt_d    = '0;
        led_d    = led;
        done_d   = 1'b0;
        error_d  = 1'b0;

        if (new_rx_data) begin
            // A byte always wins over a timeout firing in the same cycle.
            unique case (state_q)
                S_IDLE: begin
                    if (rx_data == ASCII_L) begin
                        state_d = S_HEX_HI;
                    end else if (rx_data == ASCII_C) begin
                        state_d  = S_TERM;
                        staged_d = 8'h00;
                    end else if (!is_term) begin
                        error_d = 1'b1;
                        state_d = S_DISCARD;
                    end
                end
                S_HEX_HI, S_HEX_LO: begin
                    if (hx.valid) begin
                        if (state_q == S_HEX_HI) begin
                            staged_d[7:4] = hx.nibble;
                            state_d       = S_HEX_LO;
                        end else begin
                            staged_d[3:0] = hx.nibble;
                            state_d       = S_TERM;
                        end
                    end else begin
                        error_d = 1'b1;
                        state_d = S_DISCARD;
                    end
                end
                S_TERM: begin
                    if (is_term) begin
                        led_d   = staged_q;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (is_term) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q == S_HEX_HI || state_q == S_HEX_LO || state_q == S_TERM) begin
            if (cnt_q == CNT_LAST) begin
                error_d = 1'b1;
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            led       <= 8'h00;
            cmd_done  <= 1'b0;
            cmd_error <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            led       <= led_d;
            cmd_done  <= done_d;
            cmd_error <= error_d;
        end
    end

    // Staging is always fully written before it is consumed, so it is left unreset.
    always_ff @(posedge clk) begin
        staged_q <= staged_d;
    end

`ifdef SERIAL_CMD_ACK_EN
    // Fed from the next-state pulses so the ack can issue the cycle after the pulse.
    serial_ack_sender u_ack (
        .clk         (clk),
        .rst         (rst),
        .req         (done_d | error_d),
        .req_byte    (done_d ? ASCII_K : ASCII_Q),
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data)
    );
`else
    logic unused_tx_busy;
    assign unused_tx_busy = tx_busy;
    assign tx_data        = 8'h00;
    assign new_tx_data    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_cmd_receiver.sv
// Self-checking bench for serial_cmd_receiver: a command-string parser model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_serial_cmd_receiver;

    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       new_rx_data = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic [7:0] led;
    logic       cmd_done;
    logic       cmd_error;

    int total = 0;
    int bad   = 0;

    serial_cmd_receiver #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .led         (led),
        .cmd_done    (cmd_done),
        .cmd_error   (cmd_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: text-level command parser ----------------
    byte unsigned cmd[$];
    bit           discarding = 1'b0;
    int           idle_cnt = 0;
    logic [7:0]   m_led = 8'h00;
    bit           m_done = 1'b0;
    bit           m_err = 1'b0;
    bit           busy_s = 1'b0;

    function automatic bit is_hex(input byte unsigned b);
        return (b >= "0" && b <= "9") || (b >= "a" && b <= "f") || (b >= "A" && b <= "F");
    endfunction

    function automatic logic [3:0] hex_val(input byte unsigned b);
        if (b >= "0" && b <= "9") return 4'(b - "0");
        if (b >= "a" && b <= "f") return 4'(b - "a" + 10);
        return 4'(b - "A" + 10);
    endfunction

    task automatic model_byte(input byte unsigned b);
        bit term;
        term = (b == 8'h0D) || (b == 8'h0A);
        if (discarding) begin
            if (term) discarding = 1'b0;
        end else if (cmd.size() == 0) begin
            if (b == "L" || b == "C") cmd.push_back(b);
            else if (!term) begin m_err = 1'b1; discarding = 1'b1; end
        end else if (term) begin
            if (cmd[0] == "C" && cmd.size() == 1) begin
                m_led = 8'h00; m_done = 1'b1; cmd.delete();
            end else if (cmd[0] == "L" && cmd.size() == 3) begin
                m_led = {hex_val(cmd[1]), hex_val(cmd[2])}; m_done = 1'b1; cmd.delete();
            end else begin
                m_err = 1'b1; discarding = 1'b1; cmd.delete();
            end
        end else if (cmd[0] == "L" && cmd.size() < 3 && is_hex(b)) begin
            cmd.push_back(b);
        end else begin
            m_err = 1'b1; discarding = 1'b1; cmd.delete();
        end
    endtask

    always @(posedge clk) begin
        m_done = 1'b0;
        m_err  = 1'b0;
        busy_s = tx_busy;
        if (rst) begin
            cmd.delete(); discarding = 1'b0; idle_cnt = 0; m_led = 8'h00;
        end else if (new_rx_data) begin
            idle_cnt = 0;
            model_byte(rx_data);
        end else if (cmd.size() > 0) begin
            idle_cnt++;
            if (idle_cnt == TO) begin
                m_err = 1'b1; cmd.delete(); idle_cnt = 0;
            end
        end
    end

    // ---------------- per-cycle compare and monitors ----------------
    int          n_done = 0;
    int          n_err  = 0;
    logic [7:0]  txq[$];

    always @(negedge clk) begin
        check("led", led, m_led);
        check("cmd_done", cmd_done, m_done);
        check("cmd_error", cmd_error, m_err);
        check("done_and_error", cmd_done & cmd_error, 0);
        if (cmd_done) n_done++;
        if (cmd_error) n_err++;
`ifdef SERIAL_CMD_ACK_EN
        check("tx_while_busy", new_tx_data & busy_s, 0);
        if (new_tx_data) txq.push_back(tx_data);
`else
        check("tx_tied_low", {new_tx_data, tx_data}, 0);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            rx_data     = s[i];
            new_rx_data = 1'b1;
            @(posedge clk); #1;
        end
        new_rx_data = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    int d0, e0, t0;

    initial begin
        idle(3);
        rst = 1'b0;
        check("rst_led", led, 8'h00);
        check("rst_flags", {cmd_done, cmd_error, new_tx_data}, 0);
        check("rst_tx_data", tx_data, 8'h00);

        // LA5\r back to back
        d0 = n_done; t0 = txq.size();
        send_str("LA5\r");
        check("la5_done_latency", cmd_done, 1);
        check("la5_led", led, 8'hA5);
        idle(4);
        check("la5_done_count", n_done - d0, 1);
`ifdef SERIAL_CMD_ACK_EN
        check("la5_ack_count", txq.size() - t0, 1);
        if (txq.size() > t0) check("la5_ack_byte", txq[t0], 8'h4B);
`endif

        // Lff\n then C\r
        d0 = n_done;
        send_str("Lff\n");
        idle(1);
        check("lff_led", led, 8'hFF);
        send_str("C\r");
        idle(1);
        check("clr_led", led, 8'h00);
        check("lff_c_done_count", n_done - d0, 2);

        // Malformed commands leave led alone
        send_str("L3C\r");
        idle(3);
        check("l3c_led", led, 8'h3C);
        e0 = n_err; t0 = txq.size();
        send_str("LG1\r");
        idle(1);
        check("lg1_err_count", n_err - e0, 1);
        send_str("Lx\r");
        idle(4);
        check("lx_err_count", n_err - e0, 2);
        check("bad_cmds_led", led, 8'h3C);
`ifdef SERIAL_CMD_ACK_EN
        check("bad_ack_count", txq.size() - t0, 2);
        if (txq.size() >= t0 + 2) check("bad_ack_bytes", {txq[t0], txq[t0+1]}, 16'h3F3F);
`endif

        // Timeout after a partial command
        e0 = n_err;
        send_str("L7");
        idle(TO - 1);
        check("to_not_yet", cmd_error, 0);
        idle(1);
        check("to_fires", cmd_error, 1);
        idle(2);
        check("to_err_count", n_err - e0, 1);
        send_str("L12\r");
        idle(1);
        check("after_to_led", led, 8'h12);

        // Busy transmitter: pending K overwritten by ?
        t0 = txq.size();
        tx_busy = 1'b1;
        send_str("L01\rQ");
        idle(6);
        check("busy_no_tx", txq.size() - t0, 0);
        tx_busy = 1'b0;
        idle(6);
`ifdef SERIAL_CMD_ACK_EN
        check("busy_ack_count", txq.size() - t0, 1);
        if (txq.size() > t0) check("busy_ack_byte", txq[t0], 8'h3F);
`else
        check("busy_ack_count", txq.size() - t0, 0);
`endif
        send_str("\r");
        idle(1);
        check("busy_led", led, 8'h01);

        // Reset mid-command drops the partial command and the pending ack
        tx_busy = 1'b1;
        send_str("Q\r");
        send_str("L5");
        t0 = txq.size();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("midrst_led", led, 8'h00);
        check("midrst_flags", {cmd_done, cmd_error, new_tx_data}, 0);
        tx_busy = 1'b0;
        idle(5);
        check("midrst_no_ack", txq.size() - t0, 0);
        d0 = n_done;
        send_str("C\r");
        check("midrst_c_done", cmd_done, 1);
        idle(3);
        check("midrst_c_count", n_done - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
